core_ex_csr_unit: RTL
=====================

// Module: core_ex_csr_unit
// PURPOSE
//  Machine-mode CSR file for the EX stage. Parametrised successor of the basic CSR block, adding:
//  RW/RS/RC ops, illegal-access detect, trap-entry/mret sequencing, mie/mip/mscratch, 64-bit
//  mcycle/minstret with mcountinhibit, vectored mtvec and a registered interrupt request to commit.
// PARAMETERS
//  XLEN        32  datapath width (32 only; counters are always 64 bits, split lo/hi)
//  HAS_CNT     1   1: implement mcycle/minstret(+h)/mcountinhibit; 0: read 0, writes ignored, not illegal
//  MVENDORID   0   constant returned by 0xF11
//  MARCHID     0   constant returned by 0xF12
//  MTVEC_RST   0   mtvec reset value
// PORTS
//  clk          in   1     clock, all state updates on rising edge
//  rst          in   1     asynchronous active-high reset
//  csr_en       in   1     CSR instruction valid this cycle
//  csr_op       in   2     01 RW, 10 RS, 11 RC, 00 none
//  csr_idx      in   12    CSR address
//  csr_wsrc     in   XLEN  rs1 value or zero-extended zimm
//  csr_wsrc_zero in  1     rs1==x0 / zimm==0 (suppresses RS/RC write)
//  rd_csr_dat   out  XLEN  old CSR value (combinational)
//  csr_illegal  out  1     unknown index, or write to 0xFxx read-only space
//  trap_valid   in   1     commit takes trap
//  trap_cause   in   XLEN  mcause value (bit XLEN-1 = interrupt)
//  trap_pc      in   XLEN  pc saved to mepc (bits[1:0] forced 0)
//  mret_valid   in   1     commit executes mret
//  instret      in   1     one instruction retired this cycle
//  timer_irq    in   1     level, drives mip.MTIP (bit 7)
//  ext_irq      in   1     level, drives mip.MEIP (bit 11)
//  trap_vector  out  XLEN  redirect target for trap_cause (combinational)
//  mepc_r       out  XLEN  mret target
//  irq_req      out  1     registered: mstatus.MIE & |(mie & mip)
// BEHAVIOUR
//  CSRs: mstatus 300 (MIE b3, MPIE b7, MPP b12:11 reads 11, others 0), mie 304 (b3,7,11 only),
//   mtvec 305 (mode b1:0: 00 direct, 01 vectored, 1x written as 00), mscratch 340, mepc 341
//   (b1:0 read 0), mcause 342, mip 344 (read-only view; writes ignored, not illegal), mcountinhibit
//   320 (CY b0, IR b2), mcycle B00/B80, minstret B02/B82, mvendorid F11, marchid F12.
//  Write value: RW wsrc; RS old|wsrc; RC old&~wsrc. Write occurs iff csr_en & op!=00 & !illegal &
//   !(op!=RW & wsrc_zero). Read data reflects pre-write value; new value visible next cycle.
//  csr_illegal = csr_en & op!=00 & (unknown idx | (idx[11:10]==11 & write occurs-condition)).
//  Trap entry (trap_valid): mepc<=trap_pc&~3, mcause<=trap_cause, MPIE<=MIE, MIE<=0.
//  mret (mret_valid, no trap): MIE<=MPIE, MPIE<=1.
//  Priority same cycle: trap > mret > CSR write for mstatus/mepc/mcause; other CSRs still written.
//  trap_vector: direct or exception -> {mtvec[XLEN-1:2],2'b00}; vectored & interrupt ->
//   base + 4*trap_cause[XLEN-2:0] (mod 2^XLEN).
//  Counters: mcycle +1 every cycle unless CY; minstret +instret unless IR; 64-bit carry lo->hi,
//   wrap FFFF_FFFF_FFFF_FFFF -> 0. CSR write to a half replaces that half and suppresses the
//   increment of the whole counter that cycle.
//  irq_req: flop, updated every cycle from current state; 1-cycle latency from mip/mie/MIE change.
//  Reset (async, any time): mstatus 0x1800, mie/mip-latch/mscratch/mepc/mcause/counters/
//   mcountinhibit 0, mtvec MTVEC_RST, irq_req 0. Outputs read reset values immediately.
// TESTING
//  RW 305<-0x8000_0001, read -> 0x8000_0001; write 0x8000_0003 -> reads 0x8000_0000.
//  RS 300 wsrc=0x8 -> MIE=1, read returns 0x1800; RC wsrc_zero=1 -> no change, not illegal.
//  csr_en op=RW idx=F11 -> csr_illegal=1, no state change; idx=7C0 -> illegal=1.
//  MIE=1, trap_valid cause=0x8000_0007 pc=0x102, mtvec=0x1001 -> vector 0x101C; mepc 0x100, MIE 0, MPIE 1; mret -> MIE 1.
//  mie=0x80, MIE=1, timer_irq rises cycle N -> irq_req=1 at N+1; trap same cycle as RW 300 -> trap wins.
//  mcycle lo=FFFF_FFFF -> next cycle lo 0, hi+1; CY=1 holds; write B00 same cycle as increment -> written value; rst mid-count -> 0.

Source files
------------

// File: rtl/core_ex_csr_if.sv
// EX-stage CSR bus: CSR instruction access, commit-side trap/mret events,
// interrupt lines and the redirect/interrupt results returned to commit.
interface core_ex_csr_if #(parameter int XLEN = 32);
   logic            csr_en;
   logic [1:0]      csr_op;
   logic [11:0]     csr_idx;
   logic [XLEN-1:0] csr_wsrc;
   logic            csr_wsrc_zero;
   logic [XLEN-1:0] rd_csr_dat;
   logic            csr_illegal;
   logic            trap_valid;
   logic [XLEN-1:0] trap_cause;
   logic [XLEN-1:0] trap_pc;
   logic            mret_valid;
   logic            instret;
   logic            timer_irq;
   logic            ext_irq;
   logic [XLEN-1:0] trap_vector;
   logic [XLEN-1:0] mepc_r;
   logic            irq_req;

   modport master (
      output csr_en, csr_op, csr_idx, csr_wsrc, csr_wsrc_zero,
      output trap_valid, trap_cause, trap_pc, mret_valid, instret, timer_irq, ext_irq,
      input  rd_csr_dat, csr_illegal, trap_vector, mepc_r, irq_req
   );

   modport slave (
      input  csr_en, csr_op, csr_idx, csr_wsrc, csr_wsrc_zero,
      input  trap_valid, trap_cause, trap_pc, mret_valid, instret, timer_irq, ext_irq,
      output rd_csr_dat, csr_illegal, trap_vector, mepc_r, irq_req
   );
endinterface

// File: rtl/core_ex_csr_unit.sv
// Machine-mode CSR file: RW/RS/RC access, trap entry / mret sequencing,
// 64-bit mcycle/minstret with inhibit, vectored mtvec and a registered irq request.
module core_ex_csr_unit #(
   parameter int              XLEN      = 32,
   parameter int              HAS_CNT   = 1,
   parameter logic [XLEN-1:0] MVENDORID = '0,
   parameter logic [XLEN-1:0] MARCHID   = '0,
   parameter logic [XLEN-1:0] MTVEC_RST = '0
) (
   input logic          clk,
   input logic          rst,
   core_ex_csr_if.slave bus
);
   localparam logic [1:0]      OP_NONE  = 2'b00;
   localparam logic [1:0]      OP_RW    = 2'b01;
   localparam logic [1:0]      OP_RS    = 2'b10;
   localparam logic [XLEN-1:0] MIE_MASK = XLEN'(12'h888);

   logic            st_mie, st_mpie, cy_inh, ir_inh, irq_q;
   logic [XLEN-1:0] mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q;
   logic [63:0]     mcycle_q, minstret_q;
   logic [XLEN-1:0] mip, old_val, new_val, vec_base, vec_out;
   logic            known, wr_cond, illegal, wr_en, cyc_wr, ins_wr;

   always_comb begin
      mip     = '0;
      mip[7]  = bus.timer_irq;
      mip[11] = bus.ext_irq;
   end

   always_comb begin
      old_val = '0;
      known   = 1'b1;
      case (bus.csr_idx)
         12'h300: begin
            old_val[12:11] = 2'b11;
            old_val[7]     = st_mpie;
            old_val[3]     = st_mie;
         end
         12'h304: old_val = mie_q;
         12'h305: old_val = mtvec_q;
         12'h340: old_val = mscratch_q;
         12'h341: old_val = mepc_q;
         12'h342: old_val = mcause_q;
         12'h344: old_val = mip;
         12'h320: begin
            old_val[0] = cy_inh;
            old_val[2] = ir_inh;
         end
         12'hB00: if (HAS_CNT != 0) old_val = mcycle_q[31:0];
         12'hB80: if (HAS_CNT != 0) old_val = mcycle_q[63:32];
         12'hB02: if (HAS_CNT != 0) old_val = minstret_q[31:0];
         12'hB82: if (HAS_CNT != 0) old_val = minstret_q[63:32];
         12'hF11: old_val = MVENDORID;
         12'hF12: old_val = MARCHID;
         default: known = 1'b0;
      endcase
   end

   always_comb begin
      case (bus.csr_op)
         OP_RW:   new_val = bus.csr_wsrc;
         OP_RS:   new_val = old_val | bus.csr_wsrc;
         default: new_val = old_val & ~bus.csr_wsrc;
      endcase
   end

   // RS/RC with a zero source are pure reads, so they may touch read-only space.
   assign wr_cond = bus.csr_en && (bus.csr_op != OP_NONE) &&
                    !((bus.csr_op != OP_RW) && bus.csr_wsrc_zero);
   assign illegal = bus.csr_en && (bus.csr_op != OP_NONE) &&
                    (!known || ((bus.csr_idx[11:10] == 2'b11) && wr_cond));
   assign wr_en   = wr_cond && !illegal;
   assign cyc_wr  = wr_en && (HAS_CNT != 0) && ((bus.csr_idx == 12'hB00) || (bus.csr_idx == 12'hB80));
   assign ins_wr  = wr_en && (HAS_CNT != 0) && ((bus.csr_idx == 12'hB02) || (bus.csr_idx == 12'hB82));

   assign vec_base = {mtvec_q[XLEN-1:2], 2'b00};
   assign vec_out  = ((mtvec_q[1:0] == 2'b01) && bus.trap_cause[XLEN-1]) ?
                     vec_base + {bus.trap_cause[XLEN-3:0], 2'b00} : vec_base;

   assign bus.rd_csr_dat  = old_val;
   assign bus.csr_illegal = illegal;
   assign bus.trap_vector = vec_out;
   assign bus.mepc_r      = mepc_q;
   assign bus.irq_req     = irq_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st_mie     <= 1'b0;
         st_mpie    <= 1'b0;
         cy_inh     <= 1'b0;
         ir_inh     <= 1'b0;
         irq_q      <= 1'b0;
         mie_q      <= '0;
         mtvec_q    <= MTVEC_RST;
         mscratch_q <= '0;
         mepc_q     <= '0;
         mcause_q   <= '0;
         mcycle_q   <= '0;
         minstret_q <= '0;
      end else begin
         irq_q <= st_mie & |(mie_q & mip);

         if (wr_en) begin
            case (bus.csr_idx)
               12'h304: mie_q      <= new_val & MIE_MASK;
               12'h305: mtvec_q    <= {new_val[XLEN-1:2], 1'b0, new_val[0] & ~new_val[1]};
               12'h340: mscratch_q <= new_val;
               12'h320: if (HAS_CNT != 0) begin
                  cy_inh <= new_val[0];
                  ir_inh <= new_val[2];
               end
               default: ;
            endcase
         end

         // Commit events own mstatus/mepc/mcause over a same-cycle CSR write.
         if (bus.trap_valid) begin
            mepc_q   <= {bus.trap_pc[XLEN-1:2], 2'b00};
            mcause_q <= bus.trap_cause;
            st_mpie  <= st_mie;
            st_mie   <= 1'b0;
         end else begin
            if (bus.mret_valid) begin
               st_mie  <= st_mpie;
               st_mpie <= 1'b1;
            end else if (wr_en && (bus.csr_idx == 12'h300)) begin
               st_mie  <= new_val[3];
               st_mpie <= new_val[7];
            end
            if (wr_en && (bus.csr_idx == 12'h341)) mepc_q   <= {new_val[XLEN-1:2], 2'b00};
            if (wr_en && (bus.csr_idx == 12'h342)) mcause_q <= new_val;
         end

         if (HAS_CNT != 0) begin
            if (cyc_wr) begin
               if (bus.csr_idx == 12'hB00) mcycle_q[31:0]  <= new_val;
               else                        mcycle_q[63:32] <= new_val;
            end else if (!cy_inh) begin
               mcycle_q <= mcycle_q + 64'd1;
            end
            if (ins_wr) begin
               if (bus.csr_idx == 12'hB02) minstret_q[31:0]  <= new_val;
               else                        minstret_q[63:32] <= new_val;
            end else if (!ir_inh && bus.instret) begin
               minstret_q <= minstret_q + 64'd1;
            end
         end
      end
   end
endmodule
